// File: rtl/ann_job_arbiter.sv
// ann_job_arbiter
// Shares one ANN classifier core among NUM_REQ feature-buffer requesters.
// A round-robin pointer selects the next owner. The owner gets a registered
// one-hot grant and the core gets a one-cycle run pulse. Feature data, output
// memory writes and the pass/fail result are steered between the owner and
// the core. A watchdog forces a release if the core never finishes.
module ann_job_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic [NUM_REQ-1:0]        iReq,
  input  logic [NUM_REQ*DATA_W-1:0] iFeature_bus,
  output logic [NUM_REQ-1:0]        oGrant,
  output logic [NUM_REQ-1:0]        oDone,
  output logic                      oPass,
  output logic                      oTimeout,
  output logic [ADDR_W-1:0]         oAddr_FBR_req,
  output logic [NUM_REQ-1:0]        oWrreq_OM_req,
  output logic [DATA_W-1:0]         oData_out,
  output logic                      oRun_ANN,
  output logic [DATA_W-1:0]         oFeature,
  input  logic [ADDR_W-1:0]         iAddr_FBR,
  input  logic                      iWrreq_OM,
  input  logic [DATA_W-1:0]         iData_out,
  input  logic                      iFinish_Stage,
  input  logic                      iPass
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_reg,  state_next;
  logic [NUM_REQ-1:0] grant_reg,  grant_next;
  logic [IDX_W-1:0]   owner_reg,  owner_next;
  logic [IDX_W-1:0]   ptr_reg,    ptr_next;
  logic [WD_W-1:0]    wd_reg,     wd_next;
  logic               result_reg, result_next;
  logic               flag_reg,   flag_next;
  logic               run_reg,    run_next;
  logic [NUM_REQ-1:0] done_reg,   done_next;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;

  // Cyclic index addition that also works when NUM_REQ is not a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin pick: first requester at or after ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && iReq[wrap_add(ptr_reg, i)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(ptr_reg, i);
      end
    end
  end

  // State and registered outputs; reset aborts any job without a done pulse.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      owner_reg  <= '0;
      ptr_reg    <= '0;
      wd_reg     <= '0;
      result_reg <= 1'b0;
      flag_reg   <= 1'b0;
      run_reg    <= 1'b0;
      done_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      wd_reg     <= wd_next;
      result_reg <= result_next;
      flag_reg   <= flag_next;
      run_reg    <= run_next;
      done_reg   <= done_next;
    end
  end

  // Next-state logic; pulses (run, done) default low so they last one cycle.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    owner_next  = owner_reg;
    ptr_next    = ptr_reg;
    wd_next     = wd_reg;
    result_next = result_reg;
    flag_next   = flag_reg;
    run_next    = 1'b0;
    done_next   = '0;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          grant_next = NUM_REQ'(1) << sel_idx;
          owner_next = sel_idx;
          run_next   = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_next     = '0;
        result_next = 1'b0;
        flag_next   = 1'b0;
        state_next  = BUSY;
      end
      BUSY: begin
        wd_next = wd_reg + WD_W'(1);
        // A finish on the expiry cycle takes precedence over the watchdog.
        if (iFinish_Stage) begin
          result_next = iPass;
          flag_next   = 1'b0;
          done_next   = grant_reg;
          state_next  = RELEASE;
        end else if (wd_reg == WD_W'(TIMEOUT_CYC - 1)) begin
          result_next = 1'b0;
          flag_next   = 1'b1;
          done_next   = grant_reg;
          state_next  = RELEASE;
        end
      end
      RELEASE: begin
        grant_next = '0;
        ptr_next   = wrap_add(owner_reg, 1);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-requester feature slices, masked by the registered grant.
  logic [DATA_W-1:0] feat_masked [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_feat
      assign feat_masked[gi] = grant_reg[gi] ? iFeature_bus[gi*DATA_W +: DATA_W]
                                             : '0;
    end
  endgenerate

  // OR-reduce the masked slices; yields 0 when nobody holds the grant.
  always_comb begin
    oFeature = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oFeature = oFeature | feat_masked[i];
    end
  end

  assign oGrant        = grant_reg;
  assign oDone         = done_reg;
  assign oRun_ANN      = run_reg;
  assign oPass         = result_reg & (|done_reg);
  assign oTimeout      = flag_reg & (|done_reg);
  assign oAddr_FBR_req = iAddr_FBR;
  assign oData_out     = iData_out;
  // Core writes outside BUSY have no rightful owner and are dropped.
  assign oWrreq_OM_req = (state_reg == BUSY && iWrreq_OM) ? grant_reg : '0;

endmodule

// File: doc/ann_job_arbiter.md
# ann_job_arbiter

Round-robin arbiter and job sequencer that shares one ANN classifier core among NUM_REQ feature-buffer requesters (one per scan window). It grants the core to one requester at a time and pulses the core's run input. It steers the feature-buffer read data, output-memory writes and the pass/fail result between the owning requester and the core. A watchdog recovers the arbiter if the core never reports stage completion.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 32: feature/result word width.
- ADDR_W, 7: feature-buffer address width.
- TIMEOUT_CYC, 1023: max BUSY cycles before forced release, ≥1.
- iClk  in  1  single clock, rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iReq  in  NUM_REQ  level request per requester (buffer full, job pending).
- iFeature_bus  in  NUM_REQ*DATA_W  feature-buffer read data; slice k = bits [k*DATA_W +: DATA_W].
- oGrant  out  NUM_REQ  one-hot owner, registered.
- oDone  out  NUM_REQ  one-cycle completion pulse to the owner.
- oPass  out  1  job result, valid only while any oDone bit is high.
- oTimeout  out  1  one-cycle pulse, coincident with oDone, when the job was watchdog-released.
- oAddr_FBR_req  out  ADDR_W  feature-buffer address, broadcast to all requesters.
- oWrreq_OM_req  out  NUM_REQ  output-memory write strobe routed to the owner.
- oData_out  out  DATA_W  core result data forwarded to the requesters.
- oRun_ANN  out  1  one-cycle start pulse to the core, registered.
- oFeature  out  DATA_W  owner's feature slice to the core.
- iAddr_FBR  in  ADDR_W  feature address from the core.
- iWrreq_OM  in  1  output-memory write strobe from the core.
- iData_out  in  DATA_W  result data from the core.
- iFinish_Stage  in  1  core stage-complete pulse.
- iPass  in  1  core pass flag, valid with iFinish_Stage.

## Operation
- FSM states: IDLE, LAUNCH, BUSY, RELEASE.
- IDLE: if any iReq bit is set, select the first requester at or after ptr (cyclic search) and register oGrant. Go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH: oRun_ANN=1 for this cycle only. Clear the watchdog to 0. Go to BUSY.
- BUSY: watchdog increments each cycle.
  - iFinish_Stage=1: latch iPass into the result register, go to RELEASE.
  - Else watchdog == TIMEOUT_CYC-1: result=0, set the timeout flag, go to RELEASE.
- RELEASE: oDone[owner]=1 and oPass=result; oTimeout=flag. Clear oGrant. ptr = (owner+1) mod NUM_REQ. Go to IDLE.
- Fairness: the last owner has lowest priority next round. No requester waits more than NUM_REQ-1 jobs.
- Routing:
  - oAddr_FBR_req = iAddr_FBR, combinational.
  - oFeature = owner slice of iFeature_bus, combinational from the registered grant; 0 when no grant.
  - oData_out = iData_out.
  - oWrreq_OM_req[owner] = iWrreq_OM only in BUSY; all bits 0 otherwise, so core writes outside BUSY are dropped.
- Requester contract: deassert iReq at the clock edge following its oDone pulse. A request still high in IDLE after that edge is a new job.
- iReq is sampled only in IDLE. Changes in other states are ignored.

## Timing
- Reset (async, any state): state=IDLE, ptr=0, watchdog=0, result=0, flag=0. All registered outputs are 0: oGrant, oDone, oPass, oTimeout, oRun_ANN.
- iReq rises in cycle 0 while IDLE → oGrant and oRun_ANN high in cycle 1 (LAUNCH). BUSY starts in cycle 2.
- iFinish_Stage in BUSY cycle t → oDone/oPass in t+1 → IDLE in t+2. Back-to-back jobs: the next oRun_ANN is at t+3.
- Watchdog:
  - The first BUSY cycle has watchdog=0.
  - Forced release occurs after TIMEOUT_CYC BUSY cycles without finish; oDone/oTimeout follow one cycle later.
  - Counter width is clog2(TIMEOUT_CYC+1).
- Finish and watchdog expiry in the same cycle: finish wins, result=iPass, oTimeout=0.
- iFinish_Stage outside BUSY (including LAUNCH and RELEASE) is ignored and causes no oDone.
- Reset mid-BUSY: grant drops immediately, and no oDone is issued for the aborted job. Resetting the core is the system's responsibility.

## Test plan
- Single job, NUM_REQ=4:
  - Stimulus: iReq=0100; core finishes in BUSY cycle 10 with iPass=1.
  - Required: oGrant=0100 and oRun_ANN in cycle 1, oDone=0100 and oPass=1 in cycle 13.
  - Required: oFeature equals slice 2; iWrreq_OM appears only on oWrreq_OM_req[2].
- Fairness: hold iReq=1111 with each job finishing after 5 cycles → grant order 0,1,2,3,0. Every oRun_ANN is exactly one cycle wide.
- Timeout, TIMEOUT_CYC=16: iReq=0001, no finish → oDone=0001, oPass=0, oTimeout=1 exactly 16 cycles after BUSY entry.
- Finish on the expiry cycle: iFinish_Stage=1 with iPass=1 in BUSY cycle 15 (TIMEOUT_CYC=16) → oPass=1, oTimeout=0.
- Spurious inputs: iFinish_Stage and iWrreq_OM pulsed in IDLE and LAUNCH → no oDone, oWrreq_OM_req stays 0.
- Reset mid-BUSY: assert iReset in BUSY cycle 3 → all outputs 0 asynchronously. After release, iReq=0010 is granted with ptr=0 behaviour; iReq=1010 grants requester 1 first.
